// File: rtl/direction_input.sv
// Pushbutton front end: turns four bouncing direction buttons into
// one-cycle move pulses.
// Each button has a 2-flop synchronizer and a debounce counter. A small FSM
// collects presses for a short window, so diagonals come out as one move. It
// fires once, then waits for every button to be released before it arms again.
// There is no valid/ready handshake here. The consumer samples n/s/e/w every
// cycle, and each move appears as exactly one high cycle.
module direction_input #(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int CHORD_CYCLES    = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_n,
  input  logic       btn_s,
  input  logic       btn_e,
  input  logic       btn_w,
  output logic       n,
  output logic       s,
  output logic       e,
  output logic       w,
  output logic       busy,
  output logic [1:0] fsm_state
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES) + 1;
  localparam int TW = $clog2(CHORD_CYCLES) + 1;
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [TW-1:0] T_LAST  = TW'(CHORD_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    FIRE    = 2'd2,
    RELEASE = 2'd3
  } state_t;

  // Bit order everywhere: {n, s, e, w}
  logic [3:0]    raw;
  logic [3:0]    sync1, sync2, deb;
  logic [CW-1:0] cnt [4];

  state_t        state, state_d;
  logic [3:0]    mask, mask_d;
  logic [TW-1:0] timer, timer_d;
  logic [3:0]    dir_q;

  assign raw       = {btn_n, btn_s, btn_e, btn_w};
  assign fsm_state = state;
  assign {n, s, e, w} = dir_q;

  // Two-flop synchronizers; the only consumers of the raw button pins
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw;
      sync2 <= sync1;
    end
  end

  // Debounce: a level must disagree for DEBOUNCE_CYCLES straight cycles to win
  always_ff @(posedge clk) begin
    if (reset) begin
      deb <= '0;
      for (int i = 0; i < 4; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (sync2[i] == deb[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == DB_LAST) begin
          deb[i] <= sync2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  // Next-state logic: collect window, single fire, then wait for full release
  always_comb begin
    state_d = state;
    mask_d  = mask;
    timer_d = timer;
    case (state)
      IDLE: begin
        if (|deb) begin
          state_d = COLLECT;
          mask_d  = deb;
          timer_d = '0;
        end
      end
      COLLECT: begin
        mask_d = mask | deb;
        if (timer == T_LAST) begin
          state_d = FIRE;
        end else begin
          timer_d = timer + 1'b1;
        end
      end
      FIRE: begin
        state_d = RELEASE;
      end
      RELEASE: begin
        if (deb == 4'b0000) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, chord mask and registered outputs. The pulse is loaded on the edge
  // that enters FIRE, so it is high for exactly the FIRE cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      mask  <= '0;
      timer <= '0;
      dir_q <= '0;
      busy  <= 1'b0;
    end else begin
      state <= state_d;
      mask  <= mask_d;
      timer <= timer_d;
      dir_q <= (state_d == FIRE) ? mask_d : 4'b0000;
      busy  <= (state_d != IDLE);
    end
  end

endmodule

// File: tb/tb_direction_input.sv
// Directed bench for direction_input with DEBOUNCE_CYCLES=4 and CHORD_CYCLES=3.
// "Edge k" is the k-th rising edge after a scenario starts. Edge 1 is the
// first edge that samples the new raw levels. Outputs are sampled 1 time unit
// after each edge.
module tb_direction_input;

  localparam int DB  = 4;
  localparam int CH  = 3;
  localparam int RUN = 60;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       btn_n = 1'b0, btn_s = 1'b0, btn_e = 1'b0, btn_w = 1'b0;
  logic       n, s, e, w, busy;
  logic [1:0] fsm_state;

  direction_input #(.DEBOUNCE_CYCLES(DB), .CHORD_CYCLES(CH)) dut (
    .clk(clk), .reset(reset),
    .btn_n(btn_n), .btn_s(btn_s), .btn_e(btn_e), .btn_w(btn_w),
    .n(n), .s(s), .e(e), .w(w), .busy(busy), .fsm_state(fsm_state)
  );

  // Clock
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Pulse recorder: first and second pulse, plus busy rise and fall edges
  int         p_cnt, p_edge, p_edge2, rise, fall;
  logic [3:0] p_bits, p_bits2;

  typedef struct {
    string      name;
    logic [3:0] first;
    logic [3:0] second;
    int         second_at;
    int         hold;
    int         bounce;
    int         exp_cnt;
    int         exp_edge;
    logic [3:0] exp_bits;
    int         exp_rise;
    int         exp_fall;
  } vec_t;

  vec_t vecs [9];

  task automatic check_int(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic set_btns(input logic [3:0] v);
    {btn_n, btn_s, btn_e, btn_w} = v;
  endtask

  task automatic clear_rec();
    p_cnt = 0; p_edge = -1; p_edge2 = -1; rise = -1; fall = -1;
    p_bits = 4'b0000; p_bits2 = 4'b0000;
  endtask

  task automatic step_record(input int k);
    logic [3:0] dir;
    @(posedge clk);
    #1;
    dir = {n, s, e, w};
    if (dir != 4'b0000) begin
      p_cnt++;
      if (p_edge < 0) begin
        p_edge = k; p_bits = dir;
      end else if (p_edge2 < 0) begin
        p_edge2 = k; p_bits2 = dir;
      end
    end
    if (busy && rise < 0) rise = k;
    if (!busy && rise >= 0 && fall < 0) fall = k;
  endtask

  task automatic idle_gap(input int cycles);
    set_btns(4'b0000);
    repeat (cycles) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [3:0] raw_at(input vec_t v, input int k);
    logic [3:0] r;
    r = 4'b0000;
    if (k <= v.hold) begin
      if (!(k <= v.bounce && ((k - 1) / 2) % 2 != 0)) r = r | v.first;
      if (v.second_at > 0 && k >= v.second_at) r = r | v.second;
    end
    return r;
  endfunction

  initial begin
    logic [3:0] r;

    //                name          first    second   at hold bnc cnt edge bits     rise fall
    vecs[0] = '{"east_held",     4'b0010, 4'b0000, 0, 30, 0,  1, 10, 4'b0010,  7, 37};
    vecs[1] = '{"north_held",    4'b1000, 4'b0000, 0, 20, 0,  1, 10, 4'b1000,  7, 27};
    vecs[2] = '{"west_bounce",   4'b0001, 4'b0000, 0, 32, 12, 1, 22, 4'b0001, 19, 39};
    vecs[3] = '{"east_glitch",   4'b0010, 4'b0000, 0, 3,  0,  0, -1, 4'b0000, -1, -1};
    vecs[4] = '{"diag_se",       4'b0100, 4'b0010, 3, 30, 0,  1, 10, 4'b0110,  7, 37};
    vecs[5] = '{"diag_se_last",  4'b0100, 4'b0010, 4, 30, 0,  1, 10, 4'b0110,  7, 37};
    vecs[6] = '{"diag_se_late",  4'b0100, 4'b0010, 5, 30, 0,  1, 10, 4'b0100,  7, 37};
    vecs[7] = '{"opposed_ns",    4'b1100, 4'b0000, 0, 25, 0,  1, 10, 4'b1100,  7, 32};
    vecs[8] = '{"opposed_ew",    4'b0011, 4'b0000, 0, 15, 0,  1, 10, 4'b0011,  7, 22};

    // Reset block
    set_btns(4'b0000);
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_int("reset_dir", int'({n, s, e, w}), 0);
    check_int("reset_busy", int'(busy), 0);
    check_int("reset_state", int'(fsm_state), 0);
    reset = 1'b0;
    idle_gap(4);

    // Table-driven single press scenarios
    for (int v = 0; v < 9; v++) begin
      clear_rec();
      for (int k = 1; k <= RUN; k++) begin
        r = raw_at(vecs[v], k);
        set_btns(r);
        step_record(k);
      end
      check_int({vecs[v].name, "_count"}, p_cnt, vecs[v].exp_cnt);
      check_int({vecs[v].name, "_edge"}, p_edge, vecs[v].exp_edge);
      check_int({vecs[v].name, "_bits"}, int'(p_bits), int'(vecs[v].exp_bits));
      check_int({vecs[v].name, "_busy_rise"}, rise, vecs[v].exp_rise);
      check_int({vecs[v].name, "_busy_fall"}, fall, vecs[v].exp_fall);
      idle_gap(5);
    end

    // North fired and held; east pressed during RELEASE; full release; east again
    clear_rec();
    for (int k = 1; k <= 100; k++) begin
      r = 4'b0000;
      if (k < 30) r[3] = 1'b1;
      if ((k >= 15 && k < 30) || (k >= 45 && k <= 80)) r[1] = 1'b1;
      set_btns(r);
      step_record(k);
    end
    check_int("release_rearm_count", p_cnt, 2);
    check_int("release_rearm_edge1", p_edge, 10);
    check_int("release_rearm_bits1", int'(p_bits), 4'b1000);
    check_int("release_rearm_edge2", p_edge2, 54);
    check_int("release_rearm_bits2", int'(p_bits2), 4'b0010);
    idle_gap(5);

    // Reset during COLLECT with buttons released: no pulse afterwards
    clear_rec();
    for (int k = 1; k <= 7; k++) begin
      set_btns(4'b0001);
      step_record(k);
    end
    check_int("rst_collect_state_before", int'(fsm_state), 1);
    set_btns(4'b0000);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    check_int("rst_collect_dir", int'({n, s, e, w}), 0);
    check_int("rst_collect_busy", int'(busy), 0);
    check_int("rst_collect_state", int'(fsm_state), 0);
    clear_rec();
    for (int k = 9; k <= 50; k++) step_record(k);
    check_int("rst_collect_no_pulse", p_cnt, 0);
    check_int("rst_collect_no_busy", rise, -1);
    idle_gap(5);

    // Button held through reset: treated as a fresh press and fired once
    clear_rec();
    for (int k = 1; k <= 7; k++) begin
      set_btns(4'b0001);
      step_record(k);
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    clear_rec();
    for (int k = 9; k <= 60; k++) begin
      set_btns(k <= 40 ? 4'b0001 : 4'b0000);
      step_record(k);
    end
    check_int("rst_held_count", p_cnt, 1);
    check_int("rst_held_edge", p_edge, 18);
    check_int("rst_held_bits", int'(p_bits), 4'b0001);
    check_int("rst_held_busy_rise", rise, 15);
    check_int("rst_held_busy_fall", fall, 47);

    // Final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
